// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator sequencer: FSM states, opcode values
// and instruction field positions.
package accum_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_MVTO = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_XORR = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_STR  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SEQ  = 4'd10;
    localparam logic [3:0] OP_BTRU = 4'd11;
    localparam logic [3:0] OP_SUB  = 4'd12;

    localparam logic [2:0] OPI_HALT = 3'd0;
    localparam logic [2:0] OPI_ADDI = 3'd1;
    localparam logic [2:0] OPI_SUBI = 3'd2;
    localparam logic [2:0] OPI_B    = 3'd3;
    localparam logic [2:0] OPI_LSLI = 3'd4;
    localparam logic [2:0] OPI_LSRI = 3'd5;

    localparam int IR_W      = 9;
    localparam int IR_TYPE   = 8;
    localparam int IR_ROP_HI = 7;
    localparam int IR_ROP_LO = 4;
    localparam int IR_IOP_HI = 7;
    localparam int IR_IOP_LO = 5;
    localparam int IR_IMM_HI = 4;
    localparam int IR_REG_HI = 3;

    // R-type ops whose ALU result lands in the accumulator
    function automatic logic isAccROp(input logic [3:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_ADD, OP_OR, OP_XOR, OP_XORR, OP_AND,
            OP_SLT, OP_SEQ, OP_SUB: hit = 1'b1;
            default:                hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic isAccIOp(input logic [2:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OPI_ADDI, OPI_SUBI, OPI_LSLI, OPI_LSRI: hit = 1'b1;
            default:                                hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/accum_pc_unit.sv
// Program counter: synchronous clear, +1 step or signed 5-bit relative jump,
// all arithmetic wrapping modulo 2**PC_W.
module accum_pc_unit #(
    parameter int PC_W = 10
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            clear_i,
    input  logic            inc_i,
    input  logic            rel_i,
    input  logic [4:0]      relOff_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clear_i) begin
            pc_d = '0;
        end else if (rel_i) begin
            pc_d = pc_q + {{(PC_W-5){relOff_i[4]}}, relOff_i};
        end else if (inc_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/accum_seq_ctrl.sv
// Multi-cycle sequencer for the accumulator ALU: fetches into an IR, decodes,
// and drives ALU, register-file, accumulator, data-memory and PC control.
module accum_seq_ctrl
    import accum_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [8:0]       InstrIn,
    output logic [PC_W-1:0]  PcOut,
    output logic             AluType,
    output logic [3:0]       AluROp,
    output logic [2:0]       AluIOp,
    output logic [4:0]       AluImm,
    output logic [3:0]       RegAddr,
    input  logic             BranchIn,
    output logic             AccWrEn,
    output logic             RegWrEn,
    output logic             MemReq,
    output logic             MemWe,
    input  logic             MemAck,
    output logic             Busy,
    output logic             Halted,
    output logic             Fault,
    output logic [CNT_W-1:0] Retired
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state_q, state_d;
    logic [IR_W-1:0]   ir_q;
    logic [WAIT_W-1:0] waitCnt_q;
    logic [CNT_W-1:0]  retired_q;
    logic              fault_q, memReq_q, memWe_q;

    logic       isRType, isMemOp, isHaltOp, memTimeout;
    logic [3:0] rOp;
    logic [2:0] iOp;
    logic       pcClear, pcInc, pcRel, retire;
    logic [4:0] relOff;

    assign isRType    = ir_q[IR_TYPE];
    assign rOp        = ir_q[IR_ROP_HI:IR_ROP_LO];
    assign iOp        = ir_q[IR_IOP_HI:IR_IOP_LO];
    assign isMemOp    = isRType && ((rOp == OP_LOAD) || (rOp == OP_STR));
    assign isHaltOp   = !isRType && (iOp == OPI_HALT);
    // Ack on the final wait cycle still wins over the timeout
    assign memTimeout = (state_q == S_MEM) && !MemAck &&
                        (waitCnt_q == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = S_FETCH;
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                if (isMemOp)       state_d = S_MEM;
                else if (isHaltOp) state_d = S_HALT;
                else               state_d = S_FETCH;
            end
            S_MEM: begin
                if (MemAck)          state_d = S_FETCH;
                else if (memTimeout) state_d = S_HALT;
            end
            S_HALT:  if (Start) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        AccWrEn = 1'b0;
        RegWrEn = 1'b0;
        pcClear = 1'b0;
        pcInc   = 1'b0;
        pcRel   = 1'b0;
        relOff  = ir_q[IR_IMM_HI:0];
        retire  = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: pcClear = Start;
            S_EXEC: begin
                if (!isMemOp && !isHaltOp) begin
                    retire = 1'b1;
                    if (isRType) begin
                        AccWrEn = isAccROp(rOp);
                        RegWrEn = (rOp == OP_MVTO);
                        if ((rOp == OP_BTRU) && BranchIn) begin
                            pcRel  = 1'b1;
                            relOff = {ir_q[IR_REG_HI], ir_q[IR_REG_HI:0]};
                        end else begin
                            pcInc = 1'b1;
                        end
                    end else begin
                        AccWrEn = isAccIOp(iOp);
                        if (iOp == OPI_B) pcRel = 1'b1;
                        else              pcInc = 1'b1;
                    end
                end
            end
            S_MEM: begin
                if (MemAck) begin
                    AccWrEn = (rOp == OP_LOAD);
                    pcInc   = 1'b1;
                    retire  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ir_q      <= '0;
            waitCnt_q <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
            memReq_q  <= 1'b0;
            memWe_q   <= 1'b0;
        end else begin
            if (state_q == S_FETCH) ir_q <= InstrIn;
            waitCnt_q <= (state_q == S_MEM) ? waitCnt_q + WAIT_W'(1) : '0;
            if (retire && (retired_q != '1)) retired_q <= retired_q + CNT_W'(1);
            if (memTimeout) begin
                fault_q <= 1'b1;
            end else if ((state_q == S_HALT) && Start) begin
                fault_q <= 1'b0;
            end
            if ((state_q == S_EXEC) && isMemOp) begin
                memReq_q <= 1'b1;
                memWe_q  <= (rOp == OP_STR);
            end else if ((state_q == S_MEM) && (MemAck || memTimeout)) begin
                memReq_q <= 1'b0;
                memWe_q  <= 1'b0;
            end
        end
    end

    accum_pc_unit #(.PC_W(PC_W)) uPc (
        .Clk      (Clk),
        .Reset    (Reset),
        .clear_i  (pcClear),
        .inc_i    (pcInc),
        .rel_i    (pcRel),
        .relOff_i (relOff),
        .pc_o     (PcOut)
    );

    assign AluType = isRType;
    assign AluROp  = isRType ? rOp : 4'd0;
    assign AluIOp  = isRType ? 3'd0 : iOp;
    assign AluImm  = ir_q[IR_IMM_HI:0];
    assign RegAddr = ir_q[IR_REG_HI:0];
    assign MemReq  = memReq_q;
    assign MemWe   = memWe_q;
    assign Busy    = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);
    assign Halted  = (state_q == S_HALT);
    assign Fault   = fault_q;
    assign Retired = retired_q;

endmodule
